// File: rtl/matmul_tile_scheduler.sv
// matmul_tile_scheduler: walks the (i, j, kk) tile space of C = A * B,
// issues one DMA read per A and B tile, kicks the systolic array once
// both tiles are buffered and offers each finished C tile for write-back.
// All outputs come straight from flops; their next values are derived
// from the next state so they line up with the state they belong to.
module matmul_tile_scheduler #(
  parameter int SIZE       = 16,
  parameter int ELEM_BYTES = 4,
  parameter int LOG2_SIZE  = $clog2(SIZE)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [31:0]          addr_base_a,
  input  logic [31:0]          addr_base_b,
  input  logic [31:0]          m,
  input  logic [31:0]          k,
  input  logic [31:0]          n,
  output logic                 busy,
  output logic                 done,
  output logic                 dma_start,
  output logic                 dma_sel_b,
  output logic [31:0]          dma_addr,
  output logic [31:0]          dma_stride,
  output logic [LOG2_SIZE:0]   dma_rows,
  output logic [LOG2_SIZE:0]   dma_cols,
  input  logic                 dma_done,
  output logic                 comp_start,
  output logic                 comp_acc_clear,
  input  logic                 comp_done,
  output logic                 wb_valid,
  output logic [15:0]          wb_tile_i,
  output logic [15:0]          wb_tile_j,
  input  logic                 wb_ready
);

  localparam logic [31:0]        SIZE_W   = 32'(SIZE);
  localparam logic [31:0]        EB_W     = 32'(ELEM_BYTES);
  localparam logic [LOG2_SIZE:0] SIZE_EXT = (LOG2_SIZE + 1)'(SIZE);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_LOAD_A    = 4'd1,
    S_WAIT_A    = 4'd2,
    S_LOAD_B    = 4'd3,
    S_WAIT_B    = 4'd4,
    S_COMPUTE   = 4'd5,
    S_WAIT_COMP = 4'd6,
    S_WRITE     = 4'd7,
    S_DONE      = 4'd8
  } state_t;

  // Number of SIZE-wide tiles covering x elements; 33-bit sum so x near 2^32 cannot wrap.
  function automatic logic [31:0] ceil_tiles(input logic [31:0] x);
    logic [32:0] sum;
    sum = {1'b0, x} + 33'(SIZE - 1);
    sum = sum >> LOG2_SIZE;
    return sum[31:0];
  endfunction

  // Valid extent of a tile given the remaining elements along that axis.
  function automatic logic [LOG2_SIZE:0] clamp_extent(input logic [31:0] rem);
    logic [LOG2_SIZE:0] ext;
    if (rem >= SIZE_W) begin
      ext = SIZE_EXT;
    end else begin
      ext = rem[LOG2_SIZE:0];
    end
    return ext;
  endfunction

  state_t      state_q, state_d;
  logic [31:0] base_a_q, base_a_d;
  logic [31:0] base_b_q, base_b_d;
  logic [31:0] m_q, m_d;
  logic [31:0] k_q, k_d;
  logic [31:0] n_q, n_d;
  logic [31:0] mt_q, mt_d;
  logic [31:0] kt_q, kt_d;
  logic [31:0] nt_q, nt_d;
  logic [31:0] i_q, i_d;
  logic [31:0] j_q, j_d;
  logic [31:0] kk_q, kk_d;

  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                dma_start_q, dma_start_d;
  logic                dma_sel_b_q, dma_sel_b_d;
  logic [31:0]         dma_addr_q, dma_addr_d;
  logic [31:0]         dma_stride_q, dma_stride_d;
  logic [LOG2_SIZE:0]  dma_rows_q, dma_rows_d;
  logic [LOG2_SIZE:0]  dma_cols_q, dma_cols_d;
  logic                comp_start_q, comp_start_d;
  logic                comp_acc_clear_q, comp_acc_clear_d;
  logic                wb_valid_q, wb_valid_d;
  logic [15:0]         wb_tile_i_q, wb_tile_i_d;
  logic [15:0]         wb_tile_j_q, wb_tile_j_d;

  logic [31:0]         a_addr_s;
  logic [31:0]         b_addr_s;
  logic [LOG2_SIZE:0]  a_rows_s;
  logic [LOG2_SIZE:0]  k_ext_s;
  logic [LOG2_SIZE:0]  b_cols_s;

  // Next-state logic: tile walk (kk inner, j middle, i outer) and config latch.
  always_comb begin
    state_d  = state_q;
    base_a_d = base_a_q;
    base_b_d = base_b_q;
    m_d      = m_q;
    k_d      = k_q;
    n_d      = n_q;
    mt_d     = mt_q;
    kt_d     = kt_q;
    nt_d     = nt_q;
    i_d      = i_q;
    j_d      = j_q;
    kk_d     = kk_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          base_a_d = addr_base_a;
          base_b_d = addr_base_b;
          m_d      = m;
          k_d      = k;
          n_d      = n;
          mt_d     = ceil_tiles(m);
          kt_d     = ceil_tiles(k);
          nt_d     = ceil_tiles(n);
          i_d      = 32'd0;
          j_d      = 32'd0;
          kk_d     = 32'd0;
          if ((m == 32'd0) || (k == 32'd0) || (n == 32'd0)) begin
            state_d = S_DONE;
          end else begin
            state_d = S_LOAD_A;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD_A: state_d = S_WAIT_A;
      S_WAIT_A: begin
        if (dma_done) begin
          state_d = S_LOAD_B;
        end else begin
          state_d = S_WAIT_A;
        end
      end
      S_LOAD_B: state_d = S_WAIT_B;
      S_WAIT_B: begin
        if (dma_done) begin
          state_d = S_COMPUTE;
        end else begin
          state_d = S_WAIT_B;
        end
      end
      S_COMPUTE: state_d = S_WAIT_COMP;
      S_WAIT_COMP: begin
        if (comp_done) begin
          if ((kk_q + 32'd1) < kt_q) begin
            kk_d    = kk_q + 32'd1;
            state_d = S_LOAD_A;
          end else begin
            state_d = S_WRITE;
          end
        end else begin
          state_d = S_WAIT_COMP;
        end
      end
      S_WRITE: begin
        if (wb_ready) begin
          kk_d = 32'd0;
          if (j_q == (nt_q - 32'd1)) begin
            j_d = 32'd0;
            if (i_q == (mt_q - 32'd1)) begin
              state_d = S_DONE;
            end else begin
              i_d     = i_q + 32'd1;
              state_d = S_LOAD_A;
            end
          end else begin
            j_d     = j_q + 32'd1;
            state_d = S_LOAD_A;
          end
        end else begin
          state_d = S_WRITE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Tile geometry for the upcoming load, from the indices that will be current then.
  always_comb begin
    a_addr_s = base_a_d + ((i_d * k_d * SIZE_W) + (kk_d * SIZE_W)) * EB_W;
    b_addr_s = base_b_d + ((kk_d * SIZE_W * n_d) + (j_d * SIZE_W)) * EB_W;
    a_rows_s = clamp_extent(m_d - (i_d * SIZE_W));
    k_ext_s  = clamp_extent(k_d - (kk_d * SIZE_W));
    b_cols_s = clamp_extent(n_d - (j_d * SIZE_W));
  end

  // Output next values; DMA descriptor and write-back indices hold outside their load/write entry.
  always_comb begin
    busy_d           = (state_d != S_IDLE) && (state_d != S_DONE);
    done_d           = (state_d == S_DONE);
    dma_start_d      = (state_d == S_LOAD_A) || (state_d == S_LOAD_B);
    dma_sel_b_d      = dma_sel_b_q;
    dma_addr_d       = dma_addr_q;
    dma_stride_d     = dma_stride_q;
    dma_rows_d       = dma_rows_q;
    dma_cols_d       = dma_cols_q;
    comp_start_d     = (state_d == S_COMPUTE);
    comp_acc_clear_d = (state_d == S_COMPUTE) && (kk_d == 32'd0);
    wb_valid_d       = (state_d == S_WRITE);
    wb_tile_i_d      = wb_tile_i_q;
    wb_tile_j_d      = wb_tile_j_q;
    if (state_d == S_LOAD_A) begin
      dma_sel_b_d  = 1'b0;
      dma_addr_d   = a_addr_s;
      dma_stride_d = k_d * EB_W;
      dma_rows_d   = a_rows_s;
      dma_cols_d   = k_ext_s;
    end else if (state_d == S_LOAD_B) begin
      dma_sel_b_d  = 1'b1;
      dma_addr_d   = b_addr_s;
      dma_stride_d = n_d * EB_W;
      dma_rows_d   = k_ext_s;
      dma_cols_d   = b_cols_s;
    end else begin
      dma_sel_b_d  = dma_sel_b_q;
    end
    if (state_d == S_WRITE) begin
      wb_tile_i_d = i_d[15:0];
      wb_tile_j_d = j_d[15:0];
    end else begin
      wb_tile_i_d = wb_tile_i_q;
    end
  end

  // State, counters, latched config and registered outputs; reset aborts any job.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= S_IDLE;
      base_a_q         <= 32'd0;
      base_b_q         <= 32'd0;
      m_q              <= 32'd0;
      k_q              <= 32'd0;
      n_q              <= 32'd0;
      mt_q             <= 32'd0;
      kt_q             <= 32'd0;
      nt_q             <= 32'd0;
      i_q              <= 32'd0;
      j_q              <= 32'd0;
      kk_q             <= 32'd0;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
      dma_start_q      <= 1'b0;
      dma_sel_b_q      <= 1'b0;
      dma_addr_q       <= 32'd0;
      dma_stride_q     <= 32'd0;
      dma_rows_q       <= '0;
      dma_cols_q       <= '0;
      comp_start_q     <= 1'b0;
      comp_acc_clear_q <= 1'b0;
      wb_valid_q       <= 1'b0;
      wb_tile_i_q      <= 16'd0;
      wb_tile_j_q      <= 16'd0;
    end else begin
      state_q          <= state_d;
      base_a_q         <= base_a_d;
      base_b_q         <= base_b_d;
      m_q              <= m_d;
      k_q              <= k_d;
      n_q              <= n_d;
      mt_q             <= mt_d;
      kt_q             <= kt_d;
      nt_q             <= nt_d;
      i_q              <= i_d;
      j_q              <= j_d;
      kk_q             <= kk_d;
      busy_q           <= busy_d;
      done_q           <= done_d;
      dma_start_q      <= dma_start_d;
      dma_sel_b_q      <= dma_sel_b_d;
      dma_addr_q       <= dma_addr_d;
      dma_stride_q     <= dma_stride_d;
      dma_rows_q       <= dma_rows_d;
      dma_cols_q       <= dma_cols_d;
      comp_start_q     <= comp_start_d;
      comp_acc_clear_q <= comp_acc_clear_d;
      wb_valid_q       <= wb_valid_d;
      wb_tile_i_q      <= wb_tile_i_d;
      wb_tile_j_q      <= wb_tile_j_d;
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign dma_start      = dma_start_q;
  assign dma_sel_b      = dma_sel_b_q;
  assign dma_addr       = dma_addr_q;
  assign dma_stride     = dma_stride_q;
  assign dma_rows       = dma_rows_q;
  assign dma_cols       = dma_cols_q;
  assign comp_start     = comp_start_q;
  assign comp_acc_clear = comp_acc_clear_q;
  assign wb_valid       = wb_valid_q;
  assign wb_tile_i      = wb_tile_i_q;
  assign wb_tile_j      = wb_tile_j_q;

endmodule

// File: tb/tb_matmul_tile_scheduler.sv
// Self-checking bench for matmul_tile_scheduler: a tile-loop reference model
// predicts every DMA request, compute kick and write-back; random latencies,
// stalls and spurious handshakes exercise the FSM.
module tb_matmul_tile_scheduler;

  localparam int SIZE = 16;
  localparam int EB   = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] addr_base_a = 32'd0, addr_base_b = 32'd0, m = 32'd0, k = 32'd0, n = 32'd0;
  logic        busy, done, dma_start, dma_sel_b;
  logic [31:0] dma_addr, dma_stride;
  logic [4:0]  dma_rows, dma_cols;
  logic        dma_done = 1'b0;
  logic        comp_start, comp_acc_clear;
  logic        comp_done = 1'b0;
  logic        wb_valid;
  logic [15:0] wb_tile_i, wb_tile_j;
  logic        wb_ready = 1'b0;

  matmul_tile_scheduler #(.SIZE(SIZE), .ELEM_BYTES(EB)) dut (
    .clk(clk), .rst(rst), .start(start),
    .addr_base_a(addr_base_a), .addr_base_b(addr_base_b), .m(m), .k(k), .n(n),
    .busy(busy), .done(done),
    .dma_start(dma_start), .dma_sel_b(dma_sel_b), .dma_addr(dma_addr),
    .dma_stride(dma_stride), .dma_rows(dma_rows), .dma_cols(dma_cols),
    .dma_done(dma_done),
    .comp_start(comp_start), .comp_acc_clear(comp_acc_clear), .comp_done(comp_done),
    .wb_valid(wb_valid), .wb_tile_i(wb_tile_i), .wb_tile_j(wb_tile_j), .wb_ready(wb_ready)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        sel;
    logic [31:0] addr;
    logic [31:0] stride;
    logic [4:0]  rows;
    logic [4:0]  cols;
  } req_t;

  req_t        exp_dma[$];
  logic        exp_acc[$];
  logic [31:0] exp_wb[$];
  req_t        a_log[$];
  req_t        b_log[$];
  int          n_comp, n_wb, n_done;
  int          errors = 0;
  int          checks = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [4:0] ext(input longint rem);
    return (rem >= SIZE) ? 5'(SIZE) : 5'(rem);
  endfunction

  function automatic logic [63:0] outs_misc();
    return 64'({busy, done, dma_start, dma_sel_b, dma_rows, dma_cols,
                comp_start, comp_acc_clear, wb_valid, wb_tile_i, wb_tile_j});
  endfunction

  // Reference: plain nested tile loops, i outer, j middle, kk inner.
  task automatic build_model(input logic [31:0] mm, kd, nn, ba, bb);
    longint mt, kt, nt;
    req_t   r;
    exp_dma.delete(); exp_acc.delete(); exp_wb.delete();
    mt = (longint'(mm) + SIZE - 1) / SIZE;
    kt = (longint'(kd) + SIZE - 1) / SIZE;
    nt = (longint'(nn) + SIZE - 1) / SIZE;
    if (mm == 0 || kd == 0 || nn == 0) begin
      mt = 0;
    end
    for (longint i = 0; i < mt; i++) begin
      for (longint j = 0; j < nt; j++) begin
        for (longint t = 0; t < kt; t++) begin
          r.sel    = 1'b0;
          r.addr   = ba + 32'((i * SIZE * longint'(kd) + t * SIZE) * EB);
          r.stride = 32'(longint'(kd) * EB);
          r.rows   = ext(longint'(mm) - i * SIZE);
          r.cols   = ext(longint'(kd) - t * SIZE);
          exp_dma.push_back(r);
          r.sel    = 1'b1;
          r.addr   = bb + 32'((t * SIZE * longint'(nn) + j * SIZE) * EB);
          r.stride = 32'(longint'(nn) * EB);
          r.rows   = ext(longint'(kd) - t * SIZE);
          r.cols   = ext(longint'(nn) - j * SIZE);
          exp_dma.push_back(r);
          exp_acc.push_back(t == 0);
        end
        exp_wb.push_back({16'(i), 16'(j)});
      end
    end
  endtask

  task automatic do_abort();
    rst = 1'b1; dma_done = 1'b0; comp_done = 1'b0; wb_ready = 1'b0; start = 1'b0;
    #1;
    check("abort_out_addr", {dma_addr, dma_stride}, 64'd0);
    check("abort_out_misc", outs_misc(), 64'd0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk); dma_done = 1'b1; comp_done = 1'b1;
    @(negedge clk); dma_done = 1'b0; comp_done = 1'b0;
    repeat (3) begin
      check("abort_idle", {busy, dma_start, comp_start, wb_valid}, 64'd0);
      @(negedge clk);
    end
  endtask

  // dma_lat/wb_stall < 0 mean random; abort_b > 0 resets in WAIT_B of that B load.
  task automatic run_job(input logic [31:0] mm, kd, nn, ba, bb,
                         input int dma_lat, input int wb_stall, input int abort_b);
    req_t        cur, r;
    int          dcnt = 0, ccnt = 0, scnt = 0, cyc = 0;
    logic        dout = 1'b0, cout = 1'b0, wpend = 1'b0, ended = 1'b0;
    logic [31:0] wcur = 32'd0;
    logic        zero_dim;
    zero_dim = (mm == 0) || (kd == 0) || (nn == 0);
    build_model(mm, kd, nn, ba, bb);
    a_log.delete(); b_log.delete();
    n_comp = 0; n_wb = 0; n_done = 0;
    @(negedge clk);
    start = 1'b1; m = mm; k = kd; n = nn; addr_base_a = ba; addr_base_b = bb;
    dma_done = 1'b0; comp_done = 1'b0; wb_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    if (!zero_dim) check("busy_after_start", 64'(busy), 64'd1);
    while (!ended) begin
      cyc++;
      dma_done = 1'b0; comp_done = 1'b0; wb_ready = 1'b0; start = 1'b0;
      if (dma_start) begin
        cur = {dma_sel_b, dma_addr, dma_stride, dma_rows, dma_cols};
        if (exp_dma.size() == 0) begin
          check("dma_extra", 64'd1, 64'd0);
        end else begin
          r = exp_dma.pop_front();
          check("dma_addr", 64'(dma_addr), 64'(r.addr));
          check("dma_stride", 64'(dma_stride), 64'(r.stride));
          check("dma_sel_rows_cols", 64'({dma_sel_b, dma_rows, dma_cols}), 64'({r.sel, r.rows, r.cols}));
        end
        if (dma_sel_b) b_log.push_back(cur); else a_log.push_back(cur);
        dcnt = (dma_lat > 0) ? dma_lat : int'($urandom_range(1, 4));
        dout = 1'b1;
      end else if (dout) begin
        check("dma_hold", 64'({dma_sel_b, dma_rows, dma_cols, dma_addr}),
              64'({cur.sel, cur.rows, cur.cols, cur.addr}));
        if (abort_b != 0 && cur.sel && b_log.size() == abort_b) begin
          do_abort();
          return;
        end
        dcnt--;
        if (dcnt == 0) begin dma_done = 1'b1; dout = 1'b0; end
      end else if ($urandom_range(0, 7) == 0) begin
        dma_done = 1'b1;
      end
      if (comp_start) begin
        n_comp++;
        if (exp_acc.size() == 0) check("comp_extra", 64'd1, 64'd0);
        else check("acc_clear", 64'(comp_acc_clear), 64'(exp_acc.pop_front()));
        ccnt = int'($urandom_range(1, 5)); cout = 1'b1;
      end else if (cout) begin
        ccnt--;
        if (ccnt == 0) begin comp_done = 1'b1; cout = 1'b0; end
      end else if ($urandom_range(0, 7) == 0) begin
        comp_done = 1'b1;
      end
      if (wb_valid) begin
        if (!wpend) begin
          n_wb++;
          if (exp_wb.size() == 0) check("wb_extra", 64'd1, 64'd0);
          else check("wb_tile", 64'({wb_tile_i, wb_tile_j}), 64'(exp_wb.pop_front()));
          wcur = {wb_tile_i, wb_tile_j}; wpend = 1'b1;
          scnt = (wb_stall >= 0) ? wb_stall : int'($urandom_range(0, 3));
        end else begin
          check("wb_hold", 64'({wb_tile_i, wb_tile_j}), 64'(wcur));
        end
        if (scnt == 0) begin wb_ready = 1'b1; wpend = 1'b0; end
        else scnt--;
      end else begin
        if (wpend) begin check("wb_dropped", 64'd1, 64'd0); wpend = 1'b0; end
        if ($urandom_range(0, 3) == 0) wb_ready = 1'b1;
      end
      if ((busy || done) && $urandom_range(0, 7) == 0) begin
        start = 1'b1; m = $urandom; k = $urandom; n = $urandom;
        addr_base_a = $urandom; addr_base_b = $urandom;
      end
      if (done) begin
        n_done++;
        check("done_busy_low", 64'(busy), 64'd0);
        check("done_all_issued", 64'(exp_dma.size() + exp_acc.size() + exp_wb.size()), 64'd0);
        if (zero_dim) check("zero_done_latency", 64'(cyc <= 3), 64'd1);
        ended = 1'b1;
      end else if (cyc > 20000) begin
        check("timeout", 64'd1, 64'd0);
        ended = 1'b1;
      end
      @(negedge clk);
    end
    start = 1'b0;
    check("idle_after_done", 64'({busy, done, dma_start}), 64'd0);
  endtask

  initial begin
    // Reset defaults with inputs wiggling.
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      start = 1'($urandom); dma_done = 1'($urandom); comp_done = 1'($urandom);
      wb_ready = 1'($urandom); m = $urandom; k = $urandom; n = $urandom;
      addr_base_a = $urandom; addr_base_b = $urandom;
      #1;
      check("rst_out_addr", {dma_addr, dma_stride}, 64'd0);
      check("rst_out_misc", outs_misc(), 64'd0);
    end
    @(negedge clk);
    rst = 1'b0; start = 1'b0; dma_done = 1'b0; comp_done = 1'b0; wb_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("idle_no_start", outs_misc(), 64'd0);
    end

    // 32x32x32 with fixed 3-cycle DMA latency.
    run_job(32'd32, 32'd32, 32'd32, 32'h1000_0010, 32'h2000_0100, 3, -1, 0);
    check("a_loads", 64'(a_log.size()), 64'd8);
    check("b_loads", 64'(b_log.size()), 64'd8);
    check("computes", 64'(n_comp), 64'd8);
    check("writebacks", 64'(n_wb), 64'd4);
    check("done_pulses", 64'(n_done), 64'd1);
    if (a_log.size() > 1 && b_log.size() > 1) begin
      check("a2_addr", 64'(a_log[1].addr), 64'h1000_0050);
      check("a2_stride", 64'(a_log[1].stride), 64'h80);
      check("b2_addr", 64'(b_log[1].addr), 64'h2000_0900);
      check("b2_stride", 64'(b_log[1].stride), 64'h80);
    end

    // Edge tiles.
    run_job(32'd20, 32'd16, 32'd40, $urandom, $urandom, -1, -1, 0);
    check("edge_writebacks", 64'(n_wb), 64'd6);
    if (a_log.size() > 3 && b_log.size() > 2) begin
      check("edge_a_i1_rows", 64'(a_log[3].rows), 64'd4);
      check("edge_a_i1_cols", 64'(a_log[3].cols), 64'd16);
      check("edge_b_j2_cols", 64'(b_log[2].cols), 64'd8);
    end

    // Zero dimension.
    run_job(32'd5, 32'd0, 32'd7, $urandom, $urandom, -1, -1, 0);
    check("zero_no_dma", 64'(a_log.size() + b_log.size()), 64'd0);
    check("zero_no_comp_wb", 64'(n_comp + n_wb), 64'd0);

    // Write-back held off for 10 cycles per tile.
    run_job(32'd17, 32'd33, 32'd18, $urandom, $urandom, -1, 10, 0);
    check("stall_writebacks", 64'(n_wb), 64'd4);

    // Reset in WAIT_B of the third tile, then a fresh job replays from the start.
    run_job(32'd32, 32'd32, 32'd32, 32'h1000_0010, 32'h2000_0100, 4, -1, 3);
    run_job(32'd32, 32'd32, 32'd32, 32'h3000_0000, 32'h4000_0000, -1, -1, 0);
    if (a_log.size() > 0) check("replay_first_a", 64'(a_log[0].addr), 64'h3000_0000);
    check("replay_writebacks", 64'(n_wb), 64'd4);

    // Random jobs.
    for (int t = 0; t < 6; t++) begin
      run_job(32'($urandom_range(1, 40)), 32'($urandom_range(1, 40)), 32'($urandom_range(1, 40)),
              $urandom, $urandom, -1, -1, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/matmul_tile_scheduler.md
Name: matmul_tile_scheduler

Overview:
Sequences a tiled matrix multiply C[m x n] = A[m x k] * B[k x n] on the SIZE x SIZE systolic array. Walks tile indices (i, j, kk) and issues one DMA read per A tile and per B tile, with base address, row stride and valid extent. Kicks the array once both tiles are buffered and requests write-back of each finished C tile. Sits between the CPU-facing configuration registers and the DMA/array datapath.

Parameters:
SIZE, 16, array dimension in elements; power of two, >= 2
ELEM_BYTES, 4, bytes per matrix element; power of two
LOG2_SIZE, $clog2(SIZE), derived; not overridden

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
start  in  1  job request; sampled only in IDLE
addr_base_a  in  32  byte address of A[0][0], row-major
addr_base_b  in  32  byte address of B[0][0], row-major
m  in  32  rows of A/C
k  in  32  cols of A / rows of B
n  in  32  cols of B/C
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse at job end
dma_start  out  1  one-cycle request pulse
dma_sel_b  out  1  0 = A tile into A buffer, 1 = B tile into B buffer
dma_addr  out  32  tile start byte address
dma_stride  out  32  byte distance between tile rows
dma_rows  out  LOG2_SIZE+1  valid rows in tile (1..SIZE)
dma_cols  out  LOG2_SIZE+1  valid cols in tile (1..SIZE)
dma_done  in  1  one-cycle completion pulse from DMA
comp_start  out  1  one-cycle pulse: run array on buffered tiles
comp_acc_clear  out  1  valid with comp_start; high when kk == 0
comp_done  in  1  one-cycle pulse: array pass finished
wb_valid  out  1  C tile ready for write-back
wb_tile_i  out  16  C tile row index
wb_tile_j  out  16  C tile col index
wb_ready  in  1  write-back accepted

Behaviour:
- Reset: state IDLE; all outputs 0; counters and latched config 0. Reset mid-job aborts immediately; any in-flight dma_done/comp_done is ignored afterwards.
- IDLE and start=1: latch addr_base_a, addr_base_b, m, k, n; compute tile counts MT=ceil(m/SIZE), KT=ceil(k/SIZE), NT=ceil(n/SIZE) as (x+SIZE-1)>>LOG2_SIZE in 33-bit arithmetic; set i=j=kk=0; busy=1 the next cycle.
- Any of m, k, n == 0: go straight to DONE; no DMA or compute activity.
- States: IDLE -> LOAD_A -> WAIT_A -> LOAD_B -> WAIT_B -> COMPUTE -> WAIT_COMP -> (kk<KT-1 ? kk++, LOAD_A : WRITE) ; WRITE -> advance -> LOAD_A or DONE ; DONE -> IDLE.
- LOAD_A: one cycle. dma_start=1, dma_sel_b=0.
  - dma_addr = base_a + (i*SIZE*k + kk*SIZE)*ELEM_BYTES.
  - dma_stride = k*ELEM_BYTES.
  - dma_rows = min(SIZE, m-i*SIZE); dma_cols = min(SIZE, k-kk*SIZE).
- LOAD_B: one cycle. dma_start=1, dma_sel_b=1.
  - dma_addr = base_b + (kk*SIZE*n + j*SIZE)*ELEM_BYTES.
  - dma_stride = n*ELEM_BYTES.
  - dma_rows = min(SIZE, k-kk*SIZE); dma_cols = min(SIZE, n-j*SIZE).
- Address arithmetic is mod 2^32; no overflow detection.
- dma_addr/stride/rows/cols/sel_b hold their values from the LOAD cycle through the matching WAIT state.
- WAIT_A/WAIT_B: stay until dma_done=1, then advance the next cycle. dma_done outside a WAIT state is ignored. Earliest legal dma_done is the cycle after dma_start.
- COMPUTE: one cycle. comp_start=1; comp_acc_clear=(kk==0). WAIT_COMP stays until comp_done=1. comp_done outside WAIT_COMP is ignored.
- WRITE: wb_valid=1 with wb_tile_i=i, wb_tile_j=j, held stable until the cycle wb_ready=1 (valid/ready transfer). wb_ready while wb_valid=0 is ignored.
- On transfer, advance: kk=0; j++; if j==NT-1 then j=0 and i++; if i==MT-1 as well, go to DONE.
- Loop order: i outer, j middle, kk inner. Totals: MT*NT*KT A loads, the same number of B loads and computes, and MT*NT write-backs.
- DONE: done=1 for one cycle, busy=0 the same cycle, return to IDLE. start in DONE is ignored; start is accepted again from the next cycle.
- start while busy is ignored; config inputs may change freely while busy.

Test Plan:
- Reset defaults: hold rst=1, toggle inputs -> all outputs 0. Deassert -> state stays IDLE until start.
- 32x32x32 job, base_a=0x1000_0010, base_b=0x2000_0100, DMA responds 3 cycles after each request -> 8 A loads, 8 B loads, 8 comp_start, 4 wb in order (0,0),(0,1),(1,0),(1,1), then one done pulse.
  - 2nd A load addr 0x1000_0050, stride 0x80.
  - 2nd B load addr 0x2000_0900, stride 0x80.
  - comp_acc_clear pattern 1,0,1,0,...
- Edge tiles, m=20, k=16, n=40 -> MT=2, KT=1, NT=3. Tile i=1 A load has rows=4, cols=16. j=2 B loads have cols=8. Every comp_acc_clear=1. 6 write-backs.
- Zero dimension, k=0 with start -> done pulse within 3 cycles; no dma_start, comp_start or wb_valid.
- Handshake stress: wb_ready held low 10 cycles -> wb_valid and indices stable throughout. Spurious dma_done/comp_done in LOAD/WRITE states -> no state change. start pulsed while busy -> ignored.
- Reset mid-job, rst asserted in WAIT_B of the 3rd tile -> outputs 0 immediately. A later dma_done is ignored. A fresh start replays from tile (0,0,0) at base_a.
